// File: rtl/pe_seq_pkg.sv
// Shared types and constants for the dense-layer feeder of the MAC processing element.
package pe_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    HEAD,
    STREAM,
    DRAIN,
    CAPT,
    FIN
  } state_e;

  localparam int          COUNT_W   = 10;
  localparam logic [31:0] FP32_ZERO = 32'h0;

endpackage

// File: rtl/pe_sequencer_if.sv
// Control, memory-read, PE-operand and result signals of pe_sequencer.
// The master side is the sequencer; the slave side is memories, PE and consumer.
interface pe_sequencer_if #(
  parameter int W_AW = 13,
  parameter int X_AW = 10,
  parameter int N_AW = 4
);
  logic            start;
  logic            ready;
  logic            done;
  logic [N_AW-1:0] bias_addr;
  logic [31:0]     bias_rdata;
  logic [W_AW-1:0] w_addr;
  logic [31:0]     w_rdata;
  logic [X_AW-1:0] x_addr;
  logic [31:0]     x_rdata;
  logic            pe_head;
  logic [31:0]     pe_w;
  logic [31:0]     pe_x;
  logic [31:0]     pe_b;
  logic [31:0]     pe_out;
  logic            res_valid;
  logic [N_AW-1:0] res_idx;
  logic [31:0]     res_data;

  modport master (
    input  start, bias_rdata, w_rdata, x_rdata, pe_out,
    output ready, done, bias_addr, w_addr, x_addr,
           pe_head, pe_w, pe_x, pe_b, res_valid, res_idx, res_data
  );

  modport slave (
    output start, bias_rdata, w_rdata, x_rdata, pe_out,
    input  ready, done, bias_addr, w_addr, x_addr,
           pe_head, pe_w, pe_x, pe_b, res_valid, res_idx, res_data
  );
endinterface

// File: rtl/pe_sequencer.sv
// Runs one dense layer through the MAC PE: per neuron a header beat, N_INPUTS operand
// beats and a zero drain beat, then captures pe_out as an indexed result.
module pe_sequencer
  import pe_seq_pkg::*;
#(
  parameter int N_INPUTS  = 784,
  parameter int N_NEURONS = 10,
  parameter int W_AW      = 13,
  parameter int X_AW      = 10,
  parameter int N_AW      = 4
) (
  input  logic           clock,
  input  logic           rst_n,
  pe_sequencer_if.master bus
);

  localparam logic [COUNT_W-1:0] LAST_J     = COUNT_W'(N_INPUTS - 1);
  localparam logic [N_AW-1:0]    LAST_N     = N_AW'(N_NEURONS - 1);
  localparam logic [W_AW-1:0]    W_STEP     = W_AW'(N_INPUTS);
  localparam logic [9:0]         N_FIELD    = 10'(N_INPUTS);
  localparam logic [31:0]        COUNT_BEAT = {22'b0, N_FIELD};

  state_e              state_q, state_d;
  logic [N_AW-1:0]     nidx_q, nidx_d;
  logic [N_AW-1:0]     bias_addr_q, bias_addr_d;
  logic [W_AW-1:0]     w_base_q, w_base_d;
  logic [W_AW-1:0]     w_addr_q, w_addr_d;
  logic [X_AW-1:0]     x_addr_q, x_addr_d;
  logic [COUNT_W-1:0]  j_q, j_d;
  logic [31:0]         bias_q, bias_d;
  logic                res_valid_q, res_valid_d;
  logic                done_q, done_d;

  always_comb begin
    state_d     = state_q;
    nidx_d      = nidx_q;
    bias_addr_d = bias_addr_q;
    w_base_d    = w_base_q;
    w_addr_d    = w_addr_q;
    x_addr_d    = x_addr_q;
    j_d         = j_q;
    bias_d      = bias_q;
    res_valid_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          nidx_d      = '0;
          w_base_d    = '0;
          bias_addr_d = '0;
          state_d     = PRE;
        end
      end
      PRE: begin
        w_addr_d = w_base_q;
        x_addr_d = '0;
        state_d  = HEAD;
      end
      HEAD: begin
        // Bias is held locally so the drain beat does not depend on the memory output.
        bias_d = bus.bias_rdata;
        j_d    = '0;
        if (N_INPUTS > 1) begin
          w_addr_d = w_addr_q + W_AW'(1);
          x_addr_d = x_addr_q + X_AW'(1);
        end
        state_d = STREAM;
      end
      STREAM: begin
        j_d = j_q + COUNT_W'(1);
        if (j_q == LAST_J) begin
          state_d = DRAIN;
        end else if (j_q + COUNT_W'(1) != LAST_J) begin
          w_addr_d = w_addr_q + W_AW'(1);
          x_addr_d = x_addr_q + X_AW'(1);
        end
      end
      DRAIN: begin
        res_valid_d = 1'b1;
        state_d     = CAPT;
      end
      CAPT: begin
        if (nidx_q == LAST_N) begin
          state_d = FIN;
        end else begin
          nidx_d      = nidx_q + N_AW'(1);
          bias_addr_d = nidx_q + N_AW'(1);
          w_base_d    = w_base_q + W_STEP;
          state_d     = PRE;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      nidx_q      <= '0;
      bias_addr_q <= '0;
      w_base_q    <= '0;
      w_addr_q    <= '0;
      x_addr_q    <= '0;
      j_q         <= '0;
      bias_q      <= FP32_ZERO;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      nidx_q      <= nidx_d;
      bias_addr_q <= bias_addr_d;
      w_base_q    <= w_base_d;
      w_addr_q    <= w_addr_d;
      x_addr_q    <= x_addr_d;
      j_q         <= j_d;
      bias_q      <= bias_d;
      res_valid_q <= res_valid_d;
      done_q      <= done_d;
    end
  end

  // Operands pass straight from the memories; zero outside the beats keeps the PE benign.
  always_comb begin
    bus.pe_w = FP32_ZERO;
    bus.pe_x = FP32_ZERO;
    bus.pe_b = FP32_ZERO;
    case (state_q)
      HEAD: begin
        bus.pe_x = COUNT_BEAT;
        bus.pe_b = bus.bias_rdata;
      end
      STREAM: begin
        bus.pe_w = bus.w_rdata;
        bus.pe_x = bus.x_rdata;
        bus.pe_b = bias_q;
      end
      DRAIN:   bus.pe_b = bias_q;
      default: ;
    endcase
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.done      = done_q;
  assign bus.bias_addr = bias_addr_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.x_addr    = x_addr_q;
  assign bus.pe_head   = (state_q == HEAD);
  assign bus.res_valid = res_valid_q;
  assign bus.res_idx   = res_valid_q ? nidx_q : '0;
  assign bus.res_data  = res_valid_q ? bus.pe_out : FP32_ZERO;

endmodule

// File: tb/tb_pe_sequencer.sv
// Bench for pe_sequencer: a small 4x2 instance for directed checks and a default-size
// instance for the long run, each with behavioural memories and an FP32 MAC PE model.
module tb_pe_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   res_cnt_a = 0, done_cnt_a = 0, res_cnt_b = 0, last_cyc_b = -1;

  logic [31:0] wmem_a [0:7];
  logic [31:0] xmem_a [0:3];
  logic [31:0] bmem_a [0:1];
  logic [31:0] bmem_b [0:15];
  real         acc_a = 0.0, acc_b = 0.0;

  pe_sequencer_if #(.W_AW(3), .X_AW(2), .N_AW(1)) ifa ();
  pe_sequencer_if ifb ();

  pe_sequencer #(.N_INPUTS(4), .N_NEURONS(2), .W_AW(3), .X_AW(2), .N_AW(1)) dut_a (
    .clock (clk),
    .rst_n (rst_a_n),
    .bus   (ifa)
  );

  pe_sequencer dut_b (
    .clock (clk),
    .rst_n (rst_b_n),
    .bus   (ifb)
  );

  function automatic real f2r(input logic [31:0] f);
    int          e;
    logic [63:0] d;
    if (f[30:0] == 31'h0) return 0.0;
    e = int'(f[30:23]) - 127 + 1023;
    d = {f[31], e[10:0], f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    int          e;
    logic [63:0] d;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memories with one-cycle registered read, and a free-running MAC PE model.
  always @(posedge clk) begin
    real p;
    ifa.bias_rdata <= bmem_a[ifa.bias_addr];
    ifa.w_rdata    <= wmem_a[ifa.w_addr];
    ifa.x_rdata    <= xmem_a[ifa.x_addr];
    p = f2r(ifa.pe_w) * f2r(ifa.pe_x);
    ifa.pe_out <= r2f(acc_a + p + f2r(ifa.pe_b));
    acc_a      <= ifa.pe_head ? 0.0 : acc_a + p;
  end

  always @(posedge clk) begin
    real p;
    ifb.bias_rdata <= bmem_b[ifb.bias_addr];
    ifb.w_rdata    <= 32'h0;
    ifb.x_rdata    <= 32'h3f800000;
    p = f2r(ifb.pe_w) * f2r(ifb.pe_x);
    ifb.pe_out <= r2f(acc_b + p + f2r(ifb.pe_b));
    acc_b      <= ifb.pe_head ? 0.0 : acc_b + p;
  end

  always @(negedge clk) begin
    exp_t e;
    if (ifa.res_valid) begin
      res_cnt_a++;
      $display("result a idx=%0d data=%08h", ifa.res_idx, ifa.res_data);
      check("sb_a_nonempty", sb_a.size() > 0, 1'b1);
      if (sb_a.size() > 0) begin
        e = sb_a.pop_front();
        check("res_idx_a", ifa.res_idx, e.idx);
        check("res_data_a", ifa.res_data, e.data);
      end
    end
    if (ifa.done) done_cnt_a++;
    if (ifb.res_valid) begin
      res_cnt_b++;
      $display("result b idx=%0d data=%08h cycle=%0d", ifb.res_idx, ifb.res_data, cyc);
      check("sb_b_nonempty", sb_b.size() > 0, 1'b1);
      if (sb_b.size() > 0) begin
        e = sb_b.pop_front();
        check("res_idx_b", ifb.res_idx, e.idx);
        check("res_data_b", ifb.res_data, e.data);
      end
      if (last_cyc_b >= 0) check("res_spacing_b", cyc - last_cyc_b, 788);
      last_cyc_b = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_a(input int idx, input logic [31:0] d);
    exp_t e;
    e.idx  = idx;
    e.data = d;
    sb_a.push_back(e);
  endtask

  task automatic load_t1();
    for (int k = 0; k < 8; k++) wmem_a[k] = 32'h3f800000;
    for (int k = 0; k < 4; k++) xmem_a[k] = 32'h40000000;
    bmem_a[0] = 32'h3f000000;
    bmem_a[1] = 32'h3f800000;
  endtask

  task automatic push_t1();
    push_a(0, 32'h41080000);
    push_a(1, 32'h41100000);
  endtask

  function automatic logic [31:0] neuron_exp(input int n);
    real s;
    s = f2r(bmem_a[n]);
    for (int k = 0; k < 4; k++) s = s + f2r(wmem_a[n*4+k]) * f2r(xmem_a[k]);
    return r2f(s);
  endfunction

  task automatic pulse_start_a();
    ifa.start = 1'b1;
    tick(1);
    ifa.start = 1'b0;
  endtask

  task automatic wait_done_a(input string tag, input int exp_cycles);
    int c;
    c = 0;
    while (!ifa.done && c < exp_cycles + 20) begin
      tick(1);
      c++;
    end
    check(tag, c, exp_cycles);
  endtask

  initial begin
    int c, rc, dc;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    rst_a_n   = 1'b0;
    rst_b_n   = 1'b0;
    load_t1();
    for (int k = 0; k < 16; k++) bmem_b[k] = r2f(real'(k) + 0.25);
    tick(2);
    check("rst_ready", ifa.ready, 1);
    check("rst_done", ifa.done, 0);
    check("rst_res_valid", ifa.res_valid, 0);
    check("rst_pe_head", ifa.pe_head, 0);
    check("rst_pe_x", ifa.pe_x, 0);
    check("rst_w_addr", ifa.w_addr, 0);
    check("rst_bias_addr", ifb.bias_addr, 0);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    tick(2);

    // Uniform operands: two known results and done latency.
    push_t1();
    pulse_start_a();
    check("t1_busy", ifa.ready, 0);
    wait_done_a("t1_done_latency", 17);
    tick(2);

    // Distinct operands: header, stream order, addresses, drain zeros.
    for (int k = 0; k < 8; k++) wmem_a[k] = r2f(real'(k + 1));
    xmem_a[0] = r2f(0.5);
    xmem_a[1] = r2f(1.0);
    xmem_a[2] = r2f(1.5);
    xmem_a[3] = r2f(2.0);
    bmem_a[0] = r2f(0.25);
    bmem_a[1] = r2f(-1.0);
    push_a(0, neuron_exp(0));
    push_a(1, neuron_exp(1));
    pulse_start_a();
    for (int n = 0; n < 2; n++) begin
      check("pre_bias_addr", ifa.bias_addr, n);
      tick(1);
      check("head_flag", ifa.pe_head, 1);
      check("head_count", ifa.pe_x, 32'h4);
      check("head_bias", ifa.pe_b, bmem_a[n]);
      check("head_w", ifa.pe_w, 0);
      check("head_w_addr", ifa.w_addr, n * 4);
      check("head_x_addr", ifa.x_addr, 0);
      for (int j = 0; j < 4; j++) begin
        tick(1);
        check("stream_head", ifa.pe_head, 0);
        check("stream_w", ifa.pe_w, wmem_a[n*4+j]);
        check("stream_x", ifa.pe_x, xmem_a[j]);
        if (j < 3) check("stream_w_addr", ifa.w_addr, n * 4 + j + 1);
      end
      tick(1);
      check("drain_w", ifa.pe_w, 0);
      check("drain_x", ifa.pe_x, 0);
      check("drain_b", ifa.pe_b, bmem_a[n]);
      tick(1);
      check("capt_valid", ifa.res_valid, 1);
      check("capt_idx", ifa.res_idx, n);
      check("capt_pe_b", ifa.pe_b, 0);
      tick(1);
    end
    check("fin_no_done_yet", ifa.done, 0);
    tick(1);
    check("done_pulse", ifa.done, 1);
    check("done_ready", ifa.ready, 1);
    tick(1);
    check("done_cleared", ifa.done, 0);

    // start re-pulsed mid-run and during the last capture is ignored.
    load_t1();
    push_t1();
    rc = res_cnt_a;
    dc = done_cnt_a;
    pulse_start_a();
    for (int k = 1; k <= 17; k++) begin
      ifa.start = (k == 4 || k == 16);
      tick(1);
    end
    check("repulse_done", ifa.done, 1);
    tick(4);
    check("repulse_idle", ifa.ready, 1);
    check("repulse_results", res_cnt_a - rc, 2);
    check("repulse_dones", done_cnt_a - dc, 1);

    // Reset during STREAM: immediate idle, no result.
    rc = res_cnt_a;
    pulse_start_a();
    tick(3);
    rst_a_n = 1'b0;
    #1;
    check("midrst_ready", ifa.ready, 1);
    check("midrst_pe_w", ifa.pe_w, 0);
    check("midrst_pe_x", ifa.pe_x, 0);
    check("midrst_pe_b", ifa.pe_b, 0);
    check("midrst_w_addr", ifa.w_addr, 0);
    check("midrst_x_addr", ifa.x_addr, 0);
    tick(2);
    rst_a_n = 1'b1;
    tick(2);
    check("midrst_no_result", res_cnt_a - rc, 0);
    push_t1();
    pulse_start_a();
    wait_done_a("restart_done_latency", 17);
    tick(2);

    // Back-to-back runs with start held high.
    push_t1();
    push_t1();
    ifa.start = 1'b1;
    tick(1);
    wait_done_a("b2b_first_done", 17);
    tick(1);
    check("b2b_relaunch", ifa.ready, 0);
    check("b2b_bias_addr", ifa.bias_addr, 0);
    ifa.start = 1'b0;
    wait_done_a("b2b_second_done", 17);
    tick(2);

    // Default-size instance: zero weights, results equal biases, 788 cycles apart.
    for (int k = 0; k < 10; k++) begin
      exp_t e;
      e.idx  = k;
      e.data = bmem_b[k];
      sb_b.push_back(e);
    end
    ifb.start = 1'b1;
    tick(1);
    ifb.start = 1'b0;
    c = 0;
    while (!ifb.done && c < 8100) begin
      tick(1);
      c++;
    end
    check("b_done_latency", c, 7881);
    tick(2);
    check("b_result_count", res_cnt_b, 10);
    check("sb_a_drained", sb_a.size(), 0);
    check("sb_b_drained", sb_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
